// File: rtl/barrett_for_3881.sv
// barrett_for_3881 -- fixed-modulus Barrett reducer, dout_r = din_a mod 3881.
// Accepts one 23-bit operand per clock and returns the canonical residue in [0, 3880].
// Build option: define BARRETT_3881_PIPE_EN to get three register stages (latency 3).
// Without it, the datapath is one register deep (latency 1).
// Arithmetic results are identical in both builds.
module barrett_for_3881 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [22:0] din_a,
  output logic        out_valid,
  output logic [11:0] dout_r
);

  localparam logic [35:0] MU      = 36'd4322;
  localparam int          SHIFT   = 24;
  localparam logic [22:0] MODQ    = 23'd3881;
  localparam logic [13:0] ONE_Q   = 14'd3881;
  localparam logic [13:0] TWO_Q   = 14'd7762;

  logic [35:0] prodEst;
  logic [11:0] qeEst;
  logic [22:0] subA;
  logic [11:0] subQe;
  logic [22:0] qProd;
  logic [13:0] rSub;
  logic [13:0] corrR;
  logic        corrV;
  logic [13:0] corrVal;
  logic [11:0] dout_d;
  logic [11:0] dout_q;
  logic        outValid_q;

  // Estimate the quotient: qe = floor(din_a * mu / 2^24), at most 2161.
  always_comb begin
    prodEst = {13'd0, din_a} * MU;
    qeEst   = 12'(prodEst >> SHIFT);
  end

`ifdef BARRETT_3881_PIPE_EN
  logic [22:0] a1_q;
  logic [11:0] qe1_q;
  logic        v1_q;
  logic [13:0] r2_q;
  logic        v2_q;

  // Registers after the estimate and subtract stages; data loads every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0;
      qe1_q <= '0;
      v1_q  <= 1'b0;
      r2_q  <= '0;
      v2_q  <= 1'b0;
    end else begin
      a1_q  <= din_a;
      qe1_q <= qeEst;
      v1_q  <= in_valid;
      r2_q  <= rSub;
      v2_q  <= v1_q;
    end
  end

  assign subA  = a1_q;
  assign subQe = qe1_q;
  assign corrR = r2_q;
  assign corrV = v2_q;
`else
  assign subA  = din_a;
  assign subQe = qeEst;
  assign corrR = rSub;
  assign corrV = in_valid;
`endif

  // Subtract the estimated multiple; the estimate never overshoots, so r stays in [0, 3q).
  always_comb begin
    qProd = {11'd0, subQe} * MODQ;
    rSub  = 14'(subA - qProd);
  end

  // Final correction: remove zero, one or two extra copies of the modulus.
  always_comb begin
    corrVal = corrR;
    if (corrR >= TWO_Q) begin
      corrVal = corrR - TWO_Q;
    end else if (corrR >= ONE_Q) begin
      corrVal = corrR - ONE_Q;
    end
    dout_d = 12'(corrVal);
  end

  // Output register; only the valid bit carries meaning about the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      outValid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      outValid_q <= corrV;
    end
  end

  assign dout_r    = dout_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_barrett_for_3881.sv
// Testbench for barrett_for_3881: behavioural delay-line model plus literal spot checks.
module tb_barrett_for_3881;

`ifdef BARRETT_3881_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [22:0] din_a = '0;
  logic        out_valid;
  logic [11:0] dout_r;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Model: what went in LAT edges ago, reduced with plain modulo arithmetic.
  bit mv [LAT];
  int md [LAT];

  // Literal-check request, handed to the compare process.
  int  reqId = 0;
  int  servedId = 0;
  int  litExp = 0;
  string litName = "";

  barrett_for_3881 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_a     (din_a),
    .out_valid (out_valid),
    .dout_r    (dout_r)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Model delay line; reset discards everything in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        mv[i] <= 1'b0;
        md[i] <= 0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] <= mv[i-1];
        md[i] <= md[i-1];
      end
      mv[0] <= in_valid;
      md[0] <= int'(din_a) % 3881;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("out_valid", int'(out_valid), int'(mv[LAT-1]));
      if (!rst_n) begin
        checkOutput("dout_in_reset", int'(dout_r), 0);
      end else if (mv[LAT-1]) begin
        checkOutput("dout_model", int'(dout_r), md[LAT-1]);
      end
      if (reqId != servedId) begin
        checkOutput({litName, "_valid"}, int'(out_valid), 1);
        checkOutput(litName, int'(dout_r), litExp);
        servedId = reqId;
      end
    end
  end

  // Drive one isolated operand and pin its result against a hand-computed literal.
  task automatic applyStimulus(input string name, input int a, input int exp);
    @(negedge clk);
    din_a    = 23'(a);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    litName = name;
    litExp  = exp;
    reqId++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] barrett_for_3881, latency %0d", LAT);
    checkEn  = 1'b1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    din_a    = 23'd5000;
    repeat (5) @(negedge clk);

    // Release reset with the operand still presented; first result is 5000 mod 3881.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    litName = "reset_release_1119";
    litExp  = 1119;
    reqId++;
    @(negedge clk);
    repeat (LAT + 1) @(negedge clk);

    // Identity sweep, back to back.
    for (int i = 0; i <= 3880; i++) begin
      din_a    = 23'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    applyStimulus("id_3880", 3880, 3880);
    applyStimulus("b_3881", 3881, 0);
    applyStimulus("b_3882", 3882, 1);
    applyStimulus("b_7761", 7761, 3880);
    applyStimulus("b_7762", 7762, 0);
    applyStimulus("b_11643", 11643, 0);
    applyStimulus("max_8388607", 8388607, 1766);
    applyStimulus("q2161_8386841", 8386841, 0);
    applyStimulus("zero", 0, 0);

    // Random stream with random bubbles.
    for (int i = 0; i < 10000; i++) begin
      din_a    = 23'($urandom_range(0, 8388607));
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // Reset while three operands are in flight.
    for (int i = 0; i < 3; i++) begin
      din_a    = 23'(8000000 + i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);

    // Pipeline still healthy after the mid-stream reset.
    applyStimulus("post_reset_5000", 5000, 1119);
    repeat (2) @(negedge clk);

    checkEn = 1'b0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
